fork_n: RTL

FORK_N -- requirements
Module: fork_n

---
 rtl/fork_n.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fork_n.sv
// -----------------------------------------------------------------------------
// fork_n
// Broadcasts one upstream 4-phase request to a masked set of N downstream
// channels and acknowledges upstream once every selected channel has
// completed its own 4-phase handshake.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst    : asynchronous active-high reset
//   r_i    : upstream request
//   d_i    : upstream data, valid while r_i is high
//   a_i    : upstream acknowledge (registered)
//   en_i   : channel enable mask, sampled when a transaction starts
//   r_o    : per-channel downstream request (registered)
//   d_o    : data broadcast to all channels (registered)
//   a_o    : per-channel downstream acknowledge
//   busy   : high whenever the controller is not idle
//   err    : sticky protocol-violation flag, cleared only by rst
//   cnt    : completed-transaction count, wraps modulo 2**CW
// -----------------------------------------------------------------------------
module fork_n #(
    parameter int N  = 2,
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r_i,
    input  logic [W-1:0]  d_i,
    output logic          a_i,
    input  logic [N-1:0]  en_i,
    output logic [N-1:0]  r_o,
    output logic [W-1:0]  d_o,
    input  logic [N-1:0]  a_o,
    output logic          busy,
    output logic          err,
    output logic [CW-1:0] cnt
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK,
        RTZ
    } state_t;

    state_t       state;
    logic [N-1:0] m;        // channels taking part in the current transaction
    logic [N-1:0] hi;       // channels whose ack has been seen high
    logic [N-1:0] lo;       // channels whose ack has been seen low again
    logic [N-1:0] hi_next;
    logic [N-1:0] lo_next;
    logic         stray;    // an ack on a channel that was never requested

    // Include this cycle's acks so completion is recognised on the same edge
    // that samples the last one; with m == 0 both compares are trivially true,
    // which gives the bypass behaviour for an empty mask.
    always_comb begin
        hi_next = hi | (a_o & m);
        lo_next = lo | (~a_o & m);
        stray   = |(a_o & ~m);
    end

    // NOTE: every register here is assigned with <= so all of them update
    // together from the values present before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            m     <= '0;
            hi    <= '0;
            lo    <= '0;
            a_i   <= 1'b0;
            r_o   <= '0;
            d_o   <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|a_o) begin
                        err <= 1'b1;
                    end
                    if (r_i) begin
                        m     <= en_i;
                        d_o   <= d_i;
                        r_o   <= en_i;
                        busy  <= 1'b1;
                        state <= REQ;
                    end
                end

                REQ: begin
                    hi <= hi_next;
                    if (stray) begin
                        err <= 1'b1;
                    end
                    // Withdrawal before a_i rises is flagged but the
                    // transaction is still carried through to completion.
                    if (!r_i) begin
                        err <= 1'b1;
                    end
                    if (hi_next == m) begin
                        a_i   <= 1'b1;
                        state <= ACK;
                    end
                end

                ACK: begin
                    if (stray) begin
                        err <= 1'b1;
                    end
                    if (!r_i) begin
                        r_o   <= '0;
                        hi    <= '0;
                        state <= RTZ;
                    end
                end

                RTZ: begin
                    // A fresh r_i here is ignored; IDLE picks it up next edge.
                    if (lo_next == m) begin
                        a_i   <= 1'b0;
                        lo    <= '0;
                        cnt   <= cnt + CW'(1);
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        lo <= lo_next;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
